// File: rtl/ram_sync_nxm_if.sv
// Request/response bundle for ram_sync_nxm: one write port, one read port,
// registered read data with valid strobe, and the clear-sequence busy flag.
interface ram_sync_nxm_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
);
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  read_valid;
    logic                  busy;

    modport master (
        output write_en, write_addr, data_in, read_en, read_addr,
        input  data_out, read_valid, busy
    );

    modport slave (
        input  write_en, write_addr, data_in, read_en, read_addr,
        output data_out, read_valid, busy
    );
endinterface

// File: rtl/ram_sync_nxm.sv
// Single-clock DEPTH x DATA_WIDTH RAM with registered, write-first reads and a
// post-reset sequencer that zeroes every word before accepting requests.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | clearing word[clr_cnt] each edge; busy=1, requests ignored
// ST_READY| normal operation; writes and reads accepted
module ram_sync_nxm #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ram_sync_nxm_if.slave        bus
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  read_valid_q;
    logic                  busy_q;

    logic wr_in_range;
    logic rd_in_range;
    logic wr_hit_rd;

    assign wr_in_range = ({1'b0, bus.write_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, bus.read_addr} < DEPTH_W);
    assign wr_hit_rd   = bus.write_en && wr_in_range && (bus.write_addr == bus.read_addr);

    // Storage has no reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else if (bus.write_en && wr_in_range) begin
            mem[bus.write_addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            clr_cnt      <= '0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    read_valid_q <= 1'b0;
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= ST_READY;
                        busy_q  <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    read_valid_q <= bus.read_en;
                    if (bus.read_en) begin
                        if (!rd_in_range) begin
                            data_out_q <= '0;
                        end else if (wr_hit_rd) begin
                            data_out_q <= bus.data_in;
                        end else begin
                            data_out_q <= mem[bus.read_addr];
                        end
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.read_valid = read_valid_q;
    assign bus.busy       = busy_q;

endmodule
